// File: rtl/fan_pkg.sv
// Shared types and cycle-count helpers for the fan ramp controller.
package fan_pkg;

  typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD, KICK} fan_state_e;

  function automatic int lvl_off(int n);  return 0;               endfunction
  function automatic int lvl_low(int n);  return (1 << n) / 4;    endfunction
  function automatic int lvl_mid(int n);  return (1 << n) / 2;    endfunction
  function automatic int lvl_high(int n); return (1 << n) - 1;    endfunction

  function automatic int level(int n, logic [1:0] s);
    case (s)
      2'd0:    return lvl_off(n);
      2'd1:    return lvl_low(n);
      2'd2:    return lvl_mid(n);
      default: return lvl_high(n);
    endcase
  endfunction

  function automatic int step_cyc(int sys_freq, int ramp_us);
    return sys_freq * ramp_us;
  endfunction

  function automatic int period_cyc(int sys_freq, int pwm_hz);
    return sys_freq * 1000000 / pwm_hz;
  endfunction

  function automatic int kick_cyc(int sys_freq, int kick_ms);
    return sys_freq * 1000 * kick_ms;
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Fixed-frequency PWM generator; threshold latched at period start so duty
// changes only land on period boundaries.
module fan_pwm_gen
  import fan_pkg::*;
#(
  parameter int SYS_FREQ    = 125,
  parameter int N           = 10,
  parameter int PWM_FREQ_HZ = 25000
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic [N-1:0] duty,
  output logic         pwm
);

  localparam int P  = period_cyc(SYS_FREQ, PWM_FREQ_HZ);
  localparam int CW = $clog2(P);
  localparam int MW = N + CW;

  logic [CW-1:0] cnt, thr, thr_new, thr_use;
  logic [MW-1:0] prod;
  logic          full, full_use;

  assign prod     = MW'(duty) * MW'(P);
  assign thr_new  = CW'(prod >> N);
  // At cnt==0 the freshly computed values drive the compare directly.
  assign thr_use  = (cnt == '0) ? thr_new : thr;
  assign full_use = (cnt == '0) ? (&duty) : full;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt  <= '0;
      thr  <= '0;
      full <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(P - 1)) ? '0 : cnt + 1'b1;
      if (cnt == '0) begin
        thr  <= thr_new;
        full <= &duty;
      end
      pwm <= full_use | (cnt < thr_use);
    end
  end

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan speed-level controller: ramps duty one LSB per tick toward the requested
// level. Optional kick-start on spin-up enabled by FAN_KICKSTART_EN.
module fan_ramp_ctrl
  import fan_pkg::*;
#(
  parameter int SYS_FREQ     = 125,
  parameter int N            = 10,
  parameter int PWM_FREQ_HZ  = 25000,
  parameter int RAMP_STEP_US = 1000,
  parameter int KICK_MS      = 200
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic [1:0]   speed_req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         pwm,
  output logic [N-1:0] duty_cur,
  output logic         at_target,
  output logic         busy
);

  localparam int STEP_C = step_cyc(SYS_FREQ, RAMP_STEP_US);
  localparam int KICK_C = kick_cyc(SYS_FREQ, KICK_MS);
  // One counter serves both ramp ticks and the kick interval.
  localparam int CW     = $clog2(((STEP_C > KICK_C) ? STEP_C : KICK_C) + 1);

  fan_state_e    state, state_nx;
  logic [N-1:0]  tgt, tgt_nx, duty_nx, req_lvl;
  logic [CW-1:0] cnt, cnt_nx;
  logic          acc, step;

  assign req_lvl   = N'(level(N, speed_req));
  assign acc       = req_valid && req_ready;
  assign step      = (cnt == CW'(STEP_C - 1));
  assign at_target = (duty_cur == tgt);

  always_comb begin
    state_nx  = state;
    duty_nx   = duty_cur;
    tgt_nx    = tgt;
    cnt_nx    = '0;
    req_ready = (state == IDLE) || (state == HOLD);
    busy      = (state == RAMP_UP) || (state == RAMP_DOWN) || (state == KICK);
    if (acc) tgt_nx = req_lvl;
    case (state)
      IDLE: if (acc && req_lvl != '0) begin
`ifdef FAN_KICKSTART_EN
        state_nx = KICK;
        duty_nx  = '1;
`else
        state_nx = RAMP_UP;
`endif
      end
      HOLD: if (acc) begin
        if (req_lvl > duty_cur)      state_nx = RAMP_UP;
        else if (req_lvl < duty_cur) state_nx = RAMP_DOWN;
      end
      RAMP_UP: begin
        cnt_nx = cnt + 1'b1;
        if (step) begin
          cnt_nx  = '0;
          duty_nx = duty_cur + 1'b1;
          if (duty_nx == tgt) state_nx = HOLD;
        end
      end
      RAMP_DOWN: begin
        cnt_nx = cnt + 1'b1;
        if (step) begin
          cnt_nx  = '0;
          duty_nx = duty_cur - 1'b1;
          if (duty_nx == tgt) state_nx = (tgt == '0) ? IDLE : HOLD;
        end
      end
`ifdef FAN_KICKSTART_EN
      KICK: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(KICK_C - 1)) begin
          cnt_nx   = '0;
          state_nx = (&tgt) ? HOLD : RAMP_DOWN;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state    <= IDLE;
      duty_cur <= '0;
      tgt      <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      duty_cur <= duty_nx;
      tgt      <= tgt_nx;
      cnt      <= cnt_nx;
    end
  end

  fan_pwm_gen #(
    .SYS_FREQ    (SYS_FREQ),
    .N           (N),
    .PWM_FREQ_HZ (PWM_FREQ_HZ)
  ) u_pwm (
    .clk     (clk),
    .reset_p (reset_p),
    .duty    (duty_cur),
    .pwm     (pwm)
  );

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Scoreboard bench for fan_ramp_ctrl: expected duty trajectory is queued at
// request time and popped each cycle; PWM checked by high-cycle counts.
module tb_fan_ramp_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_p = 1'b1;
  logic [1:0]   speed_req = 2'd0;
  logic         req_valid = 1'b0;
  logic         req_ready, pwm, at_target, busy;
  logic [N-1:0] duty_cur;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  fan_ramp_ctrl #(
    .SYS_FREQ(1), .N(N), .PWM_FREQ_HZ(62500), .RAMP_STEP_US(2), .KICK_MS(1)
  ) dut (
    .clk(clk), .reset_p(reset_p), .speed_req(speed_req), .req_valid(req_valid),
    .req_ready(req_ready), .pwm(pwm), .duty_cur(duty_cur),
    .at_target(at_target), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_status(string name, logic rdy, logic at, logic bsy);
    total++;
    if (req_ready !== rdy || at_target !== at || busy !== bsy) begin
      bad++;
      $display("FAIL %s: ready/at_target/busy got %b%b%b want %b%b%b",
               name, req_ready, at_target, busy, rdy, at, bsy);
    end
  endtask

  // Issue a request on one cycle; returns at the negedge after the accepting edge.
  task automatic accept(string name, logic [1:0] lvl);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_before: got %b want 1", name, req_ready);
    end
    speed_req = lvl;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Expected duty at cycle j after acceptance: flat for `hold` cycles, then one
  // LSB per 2 cycles toward tgt, saturating.
  task automatic run_ramp(string name, int start, int tgt, int hold, int span,
                          int pulse_at);
    for (int j = 0; j <= span; j++) begin
      int k, d;
      k = (j < hold) ? 0 : (j - hold) / 2;
      d = (tgt > start) ? ((start + k > tgt) ? tgt : start + k)
                        : ((start - k < tgt) ? tgt : start - k);
      exp_q.push_back(d);
    end
    for (int j = 0; j <= span; j++) begin
      int e;
      if (j > 0) @(negedge clk);
      req_valid = (j == pulse_at);
      speed_req = 2'd2;
      e = exp_q.pop_front();
      total++;
      if (duty_cur !== N'(e)) begin
        bad++;
        $display("FAIL %s_duty j=%0d: got %0d want %0d", name, j, duty_cur, e);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic check_pwm(string name, int want_high);
    int hi;
    hi = 0;
    repeat (18) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (pwm === 1'b1) hi++;
    end
    total++;
    if (hi != want_high) begin
      bad++;
      $display("FAIL %s_pwm: high cycles per 32 got %0d want %0d", name, hi, want_high);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (pwm !== 1'b0 || duty_cur !== '0) begin
      bad++;
      $display("FAIL reset_out: pwm=%b duty=%0d want 0 0", pwm, duty_cur);
    end
    check_status("reset", 1'b1, 1'b1, 1'b0);
    reset_p = 1'b0;
    @(negedge clk);
    check_status("post_reset", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_ramp_up();
    accept("up", 2'd3);
    check_status("up_start", 1'b0, 1'b0, 1'b1);
    run_ramp("up", 0, 15, 0, 30, -1);
    check_status("up_hold", 1'b1, 1'b1, 1'b0);
    check_pwm("up_full", 32);
  endtask

  task automatic test_ramp_down();
    accept("down", 2'd1);
    check_status("down_start", 1'b0, 1'b0, 1'b1);
    run_ramp("down", 15, 4, 0, 22, -1);
    check_status("down_hold", 1'b1, 1'b1, 1'b0);
    check_pwm("down_quarter", 8);
  endtask

  task automatic test_off_ignore();
    accept("off", 2'd0);
    // A mid request while not ready must not disturb the trajectory.
    run_ramp("off", 4, 0, 0, 8, 3);
    check_status("off_idle", 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (duty_cur !== '0) begin
      bad++;
      $display("FAIL off_stay: duty got %0d want 0", duty_cur);
    end
    check_pwm("off_zero", 0);
  endtask

  task automatic test_reset_mid();
    accept("mid", 2'd3);
    run_ramp("mid", 0, 15, 0, 14, -1);
    #2 reset_p = 1'b1;
    #1;
    total++;
    if (pwm !== 1'b0 || duty_cur !== '0) begin
      bad++;
      $display("FAIL midreset_out: pwm=%b duty=%0d want 0 0", pwm, duty_cur);
    end
    check_status("midreset", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
    check_status("midreset_after", 1'b1, 1'b1, 1'b0);
  endtask

`ifdef FAN_KICKSTART_EN
  task automatic test_kick();
    accept("kick", 2'd2);
    check_status("kick_start", 1'b0, 1'b0, 1'b1);
    run_ramp("kick", 15, 8, 1000, 1014, -1);
    check_status("kick_hold", 1'b1, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_off_ignore();
    test_reset_mid();
`ifdef FAN_KICKSTART_EN
    test_kick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fan_ramp_ctrl.md
Name: fan_ramp_ctrl

Overview:
Speed-level controller for the fan PWM output. Accepts discrete speed requests over a valid/ready handshake. Ramps the PWM duty one step per ramp tick toward the level target, so fan current never changes abruptly. Drives the fan pin through an internal fixed-frequency PWM generator and exposes current duty and status to the FND/LED display logic.

Parameters:
SYS_FREQ, 125, system clock in MHz
N, 10, duty resolution in bits; duty range 0..2^N-1
PWM_FREQ_HZ, 25000, PWM carrier frequency
RAMP_STEP_US, 1000, microseconds per one-LSB duty step
KICK_MS, 200, kick-start duration (optional feature only)

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous active-high reset
speed_req  in  2  requested level: 0 off, 1 low, 2 mid, 3 high
req_valid  in  1  speed_req is valid
req_ready  out  1  request can be accepted this cycle
pwm  out  1  fan PWM output
duty_cur  out  N  duty currently applied to the generator
at_target  out  1  duty_cur equals the latched target
busy  out  1  state is RAMP_UP, RAMP_DOWN or KICK

Behaviour:
- Reset is asynchronous (reset_p, active-high) on clock clk. All state clears immediately: state IDLE, duty_cur=0, target=0, pwm=0, at_target=1, busy=0, req_ready=1, all counters 0. This also applies mid-ramp.
- Level table (2^N scale): OFF=0, LOW=2^N/4, MID=2^N/2, HIGH=2^N-1.
- Handshake:
  - req_ready=1 only in IDLE and HOLD.
  - Request accepted when req_valid && req_ready. Target is latched on that edge.
  - The state transition happens on the same edge. req_ready drops on the next cycle if a ramp starts.
  - Requests while req_ready=0 are ignored. Nothing is queued.
- States:
  - IDLE: duty_cur=0. Accept with target>0 -> RAMP_UP. Accept with 0 -> stay.
  - HOLD: duty_cur==target>0. Accept target>duty -> RAMP_UP. Target<duty -> RAMP_DOWN. Equal -> stay.
  - RAMP_UP: on each ramp tick, duty_cur+=1. When duty_cur reaches target -> HOLD.
  - RAMP_DOWN: on each ramp tick, duty_cur-=1. On reaching target -> HOLD, or IDLE if target==0.
- Ramp tick:
  - Counter period STEP_CYC = SYS_FREQ*RAMP_STEP_US cycles.
  - Counter cleared on request acceptance; first step occurs STEP_CYC cycles later.
  - duty_cur saturates at target; it never over- or undershoots. No wrap.
- at_target is combinational: (duty_cur==target).
- PWM generator:
  - Period counter, PERIOD_CYC = SYS_FREQ*1_000_000/PWM_FREQ_HZ.
  - At period start (cnt==0), threshold = (duty_cur*PERIOD_CYC)>>N is latched. Duty changes are glitch-free: they take effect only at the next period boundary.
  - pwm=1 while cnt<threshold.
  - Special cases: duty_cur=0 -> pwm constantly 0. duty_cur=2^N-1 -> pwm constantly 1 (overrides the threshold).
  - pwm is registered: one cycle latency from the compare.
- Multiply width: N + clog2(PERIOD_CYC) bits, no truncation before the shift.

Optional Feature:
FAN_KICKSTART_EN
- Defined: accepting a nonzero request from IDLE enters state KICK. In KICK, duty_cur=2^N-1 for KICK_MS ms (SYS_FREQ*1000*KICK_MS cycles), busy=1, req_ready=0. Then -> RAMP_DOWN to target, or HOLD if target is HIGH.
- Undefined: no KICK state; IDLE goes straight to RAMP_UP.

Decomposition:
- Package fan_pkg holds:
  - state enum IDLE/RAMP_UP/RAMP_DOWN/HOLD/KICK
  - level constants LVL_OFF/LVL_LOW/LVL_MID/LVL_HIGH as functions of N
  - cycle-count helper constants STEP_CYC, PERIOD_CYC, KICK_CYC
- One sub-module, fan_pwm_gen: period counter, threshold latch and compare. Parameters SYS_FREQ, N, PWM_FREQ_HZ. Inputs clk, reset_p, duty. Output pwm.

Test Plan (bench params SYS_FREQ=1, N=4, PWM_FREQ_HZ=62500 so PERIOD_CYC=16, RAMP_STEP_US=2; feature off unless stated):
- Reset pulse -> pwm=0, duty_cur=0, req_ready=1, at_target=1, busy=0.
- From IDLE, accept speed_req=3 -> duty_cur increments every 2 cycles and reaches 15 after 30 cycles. Then HOLD, at_target=1, pwm constantly 1 from the next period.
- In HOLD at 15, accept speed_req=1 -> ramps down to 4 in 22 cycles. Then pwm high exactly 4 of every 16 cycles.
- Accept speed_req=0 from HOLD at 4 -> reaches 0 after 8 cycles, state IDLE, pwm constantly 0. During the ramp, pulse req_valid with speed_req=2 while req_ready=0 -> ignored, target unchanged.
- Assert reset_p mid-RAMP_UP at duty_cur=7 -> all outputs return to reset values asynchronously, within the same cycle.
- With FAN_KICKSTART_EN and KICK_MS=1 (1000 cycles), accept speed_req=2 -> duty_cur=15 for 1000 cycles, then ramps down to 8 in 14 cycles, then HOLD.
